// File: rtl/andn_vector_sequencer.sv
// andn_vector_sequencer: sweeps a shared N-bit input bus over [vec_lo..vec_hi] and checks three andN results against &a.
// Optional ANDN_SEQ_STOP_ON_ERR_EN: end the sweep at the first failing vector. Rev 1.0
`default_nettype none

module andn_vector_sequencer #(
  parameter int N      = 8,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     vec_lo,
  input  logic [N-1:0]     vec_hi,
  output logic [N-1:0]     a,
  input  logic             y_sv,
  input  logic             y_v,
  input  logic             y_vhd,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] errors,
  output logic [N:0]       vec_count,
  output logic [N-1:0]     first_err_vec,
  output logic             err_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] c_settle_last = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_cur;
  logic [N-1:0]     r_hi;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_first;
  logic [3:0]       r_wait;
  logic             r_busy;
  logic             r_err_valid;
  logic [ERR_W-1:0] r_errors;
  logic [N:0]       r_vec_count;

  logic w_exp;
  logic w_fail;
  logic w_last;
  logic w_wait_done;

  assign w_exp       = &r_a;
  assign w_fail      = (y_sv != w_exp) || (y_v != w_exp) || (y_vhd != w_exp);
  assign w_last      = (r_cur == r_hi);
  assign w_wait_done = (r_wait == c_settle_last);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_APPLY;
      S_APPLY: w_next = (SETTLE == 0) ? S_CHECK : S_WAIT;
      S_WAIT:  if (w_wait_done) w_next = S_CHECK;
      S_CHECK: begin
`ifdef ANDN_SEQ_STOP_ON_ERR_EN
        w_next = (w_last || w_fail) ? S_DONE : S_APPLY;
`else
        w_next = w_last ? S_DONE : S_APPLY;
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur       <= '0;
      r_hi        <= '0;
      r_a         <= '0;
      r_first     <= '0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_err_valid <= 1'b0;
      r_errors    <= '0;
      r_vec_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur       <= vec_lo;
            r_hi        <= vec_hi;
            r_busy      <= 1'b1;
            r_errors    <= '0;
            r_vec_count <= '0;
            r_err_valid <= 1'b0;
          end
        end
        S_APPLY: begin
          r_a    <= r_cur;
          r_wait <= '0;
        end
        S_WAIT: r_wait <= r_wait + 4'd1;
        S_CHECK: begin
          r_vec_count <= r_vec_count + (N+1)'(1);
          if (w_fail) begin
            if (r_errors != {ERR_W{1'b1}}) r_errors <= r_errors + ERR_W'(1);
            if (!r_err_valid) begin
              r_first     <= r_a;
              r_err_valid <= 1'b1;
            end
          end
          // Counter wraps naturally, so lo > hi sweeps through all-ones to hi.
          if (!w_last) r_cur <= r_cur + N'(1);
        end
        S_DONE: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign a             = r_a;
  assign busy          = r_busy;
  assign done          = (r_state == S_DONE);
  assign errors        = r_errors;
  assign vec_count     = r_vec_count;
  assign first_err_vec = r_first;
  assign err_valid     = r_err_valid;

endmodule

`default_nettype wire

// File: tb/tb_andn_vector_sequencer.sv
// tb_andn_vector_sequencer: directed sweeps with a scoreboard checking each done pulse.
// Expectations follow ANDN_SEQ_STOP_ON_ERR_EN when it is defined. Rev 1.0
`default_nettype none

module tb_andn_vector_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vec_lo = '0;
  logic [7:0]  vec_hi = '0;
  logic [7:0]  a;
  logic        y_sv, y_v, y_vhd;
  logic        busy, done, err_valid;
  logic [15:0] errors;
  logic [8:0]  vec_count;
  logic [7:0]  first_err_vec;

  // 0 none, 1 y_vhd=0 at FF, 2 y_v stuck 1, 3 y_sv stuck 1, 4 y_v inverted
  int fault = 0;

  andn_vector_sequencer #(.N(8), .SETTLE(1), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_lo(vec_lo), .vec_hi(vec_hi),
    .a(a), .y_sv(y_sv), .y_v(y_v), .y_vhd(y_vhd), .busy(busy), .done(done),
    .errors(errors), .vec_count(vec_count), .first_err_vec(first_err_vec),
    .err_valid(err_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    y_sv  = &a;
    y_v   = &a;
    y_vhd = &a;
    case (fault)
      1: if (a == 8'hFF) y_vhd = 1'b0;
      2: y_v = 1'b1;
      3: y_sv = 1'b1;
      4: y_v = ~(&a);
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] errors;
    logic [8:0]  vc;
    logic [7:0]  fev;
    logic        ev;
    logic [7:0]  a;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("errors", {16'd0, errors}, {16'd0, e.errors});
        chk("vec_count", {23'd0, vec_count}, {23'd0, e.vc});
        chk("err_valid", {31'd0, err_valid}, {31'd0, e.ev});
        if (e.ev) chk("first_err_vec", {24'd0, first_err_vec}, {24'd0, e.fev});
        chk("a_after_sweep", {24'd0, a}, {24'd0, e.a});
        chk("latency", cyc - start_cyc, e.lat);
      end
    end
    prev_done = done;
  end

  task automatic wait_done();
    int i;
    for (i = 0; i < 3000 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic sweep(input logic [7:0] lo, input logic [7:0] hi, input int f,
                       input logic [15:0] e_err, input logic [8:0] e_vc,
                       input logic [7:0] e_fev, input logic e_ev,
                       input logic [7:0] e_a, input int e_lat);
    exp_t e;
    @(negedge clk);
    fault  = f;
    vec_lo = lo;
    vec_hi = hi;
    e.errors = e_err; e.vc = e_vc; e.fev = e_fev; e.ev = e_ev; e.a = e_a; e.lat = e_lat;
    sb.push_back(e);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_a", {24'd0, a}, 32'd0);
    chk("rst_errors", {16'd0, errors}, 32'd0);
    chk("rst_vec_count", {23'd0, vec_count}, 32'd0);
    chk("rst_first_err_vec", {24'd0, first_err_vec}, 32'd0);
    chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
    reset = 1'b0;

    sweep(8'h00, 8'hFF, 0, 16'd0, 9'd256, 8'h00, 1'b0, 8'hFF, 769);
    sweep(8'h00, 8'hFF, 1, 16'd1, 9'd256, 8'hFF, 1'b1, 8'hFF, 769);
    sweep(8'hFE, 8'h01, 0, 16'd0, 9'd4, 8'h00, 1'b0, 8'h01, 13);
    sweep(8'h5A, 8'h5A, 0, 16'd0, 9'd1, 8'h00, 1'b0, 8'h5A, 4);
`ifdef ANDN_SEQ_STOP_ON_ERR_EN
    sweep(8'hFE, 8'h01, 4, 16'd1, 9'd1, 8'hFE, 1'b1, 8'hFE, 4);
    sweep(8'hFE, 8'h01, 3, 16'd1, 9'd1, 8'hFE, 1'b1, 8'hFE, 4);
    sweep(8'h00, 8'hFF, 2, 16'd1, 9'd1, 8'h00, 1'b1, 8'h00, 4);
`else
    sweep(8'hFE, 8'h01, 4, 16'd4, 9'd4, 8'hFE, 1'b1, 8'h01, 13);
    sweep(8'hFE, 8'h01, 3, 16'd3, 9'd4, 8'hFE, 1'b1, 8'h01, 13);
    sweep(8'h00, 8'hFF, 2, 16'd255, 9'd256, 8'h00, 1'b1, 8'hFF, 769);
`endif
    sweep(8'h3C, 8'h3C, 4, 16'd1, 9'd1, 8'h3C, 1'b1, 8'h3C, 4);

    // start re-pulsed while busy with different bounds must be ignored
    @(negedge clk);
    fault = 3; vec_lo = 8'h00; vec_hi = 8'h0F;
`ifdef ANDN_SEQ_STOP_ON_ERR_EN
    e.errors = 16'd1; e.vc = 9'd1; e.fev = 8'h00; e.ev = 1'b1; e.a = 8'h00; e.lat = 4;
`else
    e.errors = 16'd16; e.vc = 9'd16; e.fev = 8'h00; e.ev = 1'b1; e.a = 8'h0F; e.lat = 49;
`endif
    sb.push_back(e);
    start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    vec_lo = 8'h80; vec_hi = 8'h81;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start during the DONE cycle is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_in_done_busy2", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // reset mid-sweep aborts without a done pulse
    fault = 0; vec_lo = 8'h00; vec_hi = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_a", {24'd0, a}, 32'd0);
    chk("abort_errors", {16'd0, errors}, 32'd0);
    chk("abort_vec_count", {23'd0, vec_count}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (10) @(negedge clk);

    sweep(8'h10, 8'h12, 0, 16'd0, 9'd3, 8'h00, 1'b0, 8'h12, 10);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
